// File: rtl/mem_pkg.sv
// Shared memory-system definitions: responder FSM states and default bus widths
// used by the controller, datapath and memory responder.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 16;
endpackage

// File: rtl/mem_responder_if.sv
// Controller <-> memory responder handshake: strobes, MAR/MDR values,
// read data and completion/error pulses.
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              MemReady;
    logic              MemErr;
    logic              busy;

    modport master (
        output MemRead, MemWrite, addr, wdata,
        input  rdata, MemReady, MemErr, busy
    );

    modport slave (
        input  MemRead, MemWrite, addr, wdata,
        output rdata, MemReady, MemErr, busy
    );
endinterface

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, registered read with enable.
// Contents are never reset; only the read register is.
module mem_array #(
    parameter int    ADDR_W    = 8,
    parameter int    DATA_W    = 16,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    // The read register holds its value between reads, so it doubles as rdata.
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// Memory responder: edge-detects MemRead/MemWrite, inserts WAIT_CYCLES busy
// cycles, then performs the access and pulses MemReady for one cycle.
module mem_responder
    import mem_pkg::*;
#(
    parameter int    ADDR_W      = MEM_ADDR_W,
    parameter int    DATA_W      = MEM_DATA_W,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic            Clk,
    input  logic            Reset,
    mem_responder_if.slave  bus
);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              read_q, write_q;
    logic              op_write;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    logic              ready_r, err_r, busy_r;
    logic [DATA_W-1:0] rdata_w;

    logic rd_rise, wr_rise, access, we, re;

    assign rd_rise = bus.MemRead  & ~read_q;
    assign wr_rise = bus.MemWrite & ~write_q;

    // Reset on the commit edge must suppress the access, hence the !Reset gate.
    assign access = (state == BUSY) && (cnt == '0) && !Reset;
    assign we     = access &&  op_write;
    assign re     = access && !op_write;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            op_write <= 1'b0;
            addr_l   <= '0;
            wdata_l  <= '0;
            ready_r  <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            read_q  <= bus.MemRead;
            write_q <= bus.MemWrite;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_rise && wr_rise) begin
                        err_r <= 1'b1;
                    end else if (rd_rise || wr_rise) begin
                        addr_l   <= bus.addr;
                        wdata_l  <= bus.wdata;
                        op_write <= wr_rise;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                        busy_r   <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        ready_r <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (Clk),
        .rst   (Reset),
        .we    (we),
        .re    (re),
        .addr  (addr_l),
        .wdata (wdata_l),
        .rdata (rdata_w)
    );

    assign bus.rdata    = rdata_w;
    assign bus.MemReady = ready_r;
    assign bus.MemErr   = err_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT_CYCLES=2, one with 0.
module tb_mem_responder;
    logic Clk = 1'b0;
    logic Reset2, Reset0;
    int   checks = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    mem_responder_if b2 ();
    mem_responder_if b0 ();

    mem_responder #(.WAIT_CYCLES(2)) u2 (.Clk(Clk), .Reset(Reset2), .bus(b2.slave));
    mem_responder #(.WAIT_CYCLES(0)) u0 (.Clk(Clk), .Reset(Reset0), .bus(b0.slave));

    // Raise one strobe, observe 10 cycles, then drop it for one cycle.
    task automatic access(input bit sel0, input bit wr, input logic [7:0] a,
                          input logic [15:0] d, output int lat, output int busy_n,
                          output int rdy_n, output logic [15:0] rd_rdy);
        logic rdy, bsy;
        logic [15:0] rd;
        if (sel0) begin
            b0.addr = a; b0.wdata = d; b0.MemWrite = wr; b0.MemRead = !wr;
        end else begin
            b2.addr = a; b2.wdata = d; b2.MemWrite = wr; b2.MemRead = !wr;
        end
        lat = 0; busy_n = 0; rdy_n = 0; rd_rdy = 'x;
        for (int i = 1; i <= 10; i++) begin
            @(posedge Clk); #1;
            rdy = sel0 ? b0.MemReady : b2.MemReady;
            bsy = sel0 ? b0.busy : b2.busy;
            rd  = sel0 ? b0.rdata : b2.rdata;
            if (bsy) busy_n++;
            if (rdy) begin
                rdy_n++;
                if (lat == 0) begin lat = i; rd_rdy = rd; end
            end
        end
        if (sel0) begin b0.MemRead = 0; b0.MemWrite = 0; end
        else begin b2.MemRead = 0; b2.MemWrite = 0; end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset;
        Reset2 = 1; Reset0 = 1;
        b2.MemRead = 0; b2.MemWrite = 0; b2.addr = 0; b2.wdata = 0;
        b0.MemRead = 0; b0.MemWrite = 0; b0.addr = 0; b0.wdata = 0;
        repeat (2) @(posedge Clk);
        #1;
        Reset2 = 0; Reset0 = 0;
        checks++; if (b2.MemReady !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0h exp=0", b2.MemReady); end
        checks++; if (b2.MemErr !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", b2.MemErr); end
        checks++; if (b2.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", b2.busy); end
        checks++; if (b2.rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", b2.rdata); end
        checks++; if (b0.rdata !== 16'h0 || b0.busy !== 1'b0) begin failures++; $display("FAIL reset_w0 got=%0h/%0h exp=0/0", b0.rdata, b0.busy); end
        @(posedge Clk); #1;
    endtask

    task automatic test_write;
        int lat, bn, rn; logic [15:0] rd;
        access(0, 1, 8'h10, 16'h000F, lat, bn, rn, rd);
        checks++; if (lat !== 4) begin failures++; $display("FAIL write_latency got=%0d exp=4", lat); end
        checks++; if (rn !== 1) begin failures++; $display("FAIL write_ready_count got=%0d exp=1", rn); end
        checks++; if (b2.rdata !== 16'h0) begin failures++; $display("FAIL write_rdata got=%0h exp=0", b2.rdata); end
    endtask

    task automatic test_read;
        int lat, bn, rn; logic [15:0] rd;
        access(0, 0, 8'h10, 16'h0, lat, bn, rn, rd);
        checks++; if (lat !== 4) begin failures++; $display("FAIL read_latency got=%0d exp=4", lat); end
        checks++; if (rd !== 16'h000F) begin failures++; $display("FAIL read_data_at_ready got=%0h exp=000f", rd); end
        checks++; if (b2.rdata !== 16'h000F) begin failures++; $display("FAIL read_data_held got=%0h exp=000f", b2.rdata); end
        checks++; if (bn !== 4) begin failures++; $display("FAIL read_busy_cycles got=%0d exp=4", bn); end
    endtask

    task automatic test_both_strobes;
        int lat, bn, rn, en; logic [15:0] rd;
        access(0, 1, 8'h30, 16'h1111, lat, bn, rn, rd);
        b2.addr = 8'h30; b2.wdata = 16'h2222; b2.MemRead = 1; b2.MemWrite = 1;
        en = 0; rn = 0; bn = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            if (b2.MemErr) en++;
            if (b2.MemReady) rn++;
            if (b2.busy) bn++;
        end
        b2.MemRead = 0; b2.MemWrite = 0;
        @(posedge Clk); #1;
        checks++; if (en !== 1) begin failures++; $display("FAIL err_pulses got=%0d exp=1", en); end
        checks++; if (rn !== 0) begin failures++; $display("FAIL err_no_ready got=%0d exp=0", rn); end
        checks++; if (bn !== 0) begin failures++; $display("FAIL err_no_busy got=%0d exp=0", bn); end
        access(0, 0, 8'h30, 16'h0, lat, bn, rn, rd);
        checks++; if (rd !== 16'h1111) begin failures++; $display("FAIL err_array_unchanged got=%0h exp=1111", rd); end
    endtask

    task automatic test_hold;
        int rn;
        b2.addr = 8'h10; b2.MemRead = 1;
        rn = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            if (b2.MemReady) rn++;
        end
        checks++; if (rn !== 1) begin failures++; $display("FAIL hold_single_ready got=%0d exp=1", rn); end
        b2.MemRead = 0;
        @(posedge Clk); #1;
        b2.MemRead = 1;
        rn = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (b2.MemReady) rn++;
        end
        b2.MemRead = 0;
        @(posedge Clk); #1;
        checks++; if (rn !== 1) begin failures++; $display("FAIL hold_reissue_ready got=%0d exp=1", rn); end
    endtask

    task automatic test_back_to_back;
        int lat, n;
        b2.addr = 8'h10; b2.MemRead = 1;
        n = 0;
        while (b2.MemReady !== 1'b1 && n < 10) begin @(posedge Clk); #1; n++; end
        b2.MemRead = 0;
        @(posedge Clk); #1;
        b2.MemRead = 1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge Clk); #1;
            if (b2.MemReady && lat == 0) lat = i;
        end
        b2.MemRead = 0;
        @(posedge Clk); #1;
        checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
        checks++; if (b2.rdata !== 16'h000F) begin failures++; $display("FAIL b2b_rdata got=%0h exp=000f", b2.rdata); end
    endtask

    task automatic test_reset_mid;
        int lat, bn, rn; logic [15:0] rd;
        access(0, 1, 8'h20, 16'h1234, lat, bn, rn, rd);
        b2.addr = 8'h20; b2.wdata = 16'hBEEF; b2.MemWrite = 1;
        rn = 0;
        repeat (3) begin @(posedge Clk); #1; if (b2.MemReady) rn++; end
        Reset2 = 1; b2.MemWrite = 0;
        @(posedge Clk); #1;
        if (b2.MemReady) rn++;
        checks++; if (b2.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0h exp=0", b2.busy); end
        Reset2 = 0;
        repeat (4) begin @(posedge Clk); #1; if (b2.MemReady) rn++; end
        checks++; if (rn !== 0) begin failures++; $display("FAIL rstmid_no_ready got=%0d exp=0", rn); end
        access(0, 0, 8'h20, 16'h0, lat, bn, rn, rd);
        checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL rstmid_no_commit got=%0h exp=1234", rd); end
    endtask

    task automatic test_wait0;
        int lat, bn, rn; logic [15:0] rd;
        access(1, 1, 8'h00, 16'hABCD, lat, bn, rn, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL w0_write_latency got=%0d exp=2", lat); end
        access(1, 1, 8'h01, 16'h5555, lat, bn, rn, rd);
        access(1, 0, 8'h00, 16'h0, lat, bn, rn, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL w0_read_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 16'hABCD) begin failures++; $display("FAIL w0_read_data got=%0h exp=abcd", rd); end
        checks++; if (bn !== 2) begin failures++; $display("FAIL w0_busy_cycles got=%0d exp=2", bn); end
        // Address moves to 0x01 while the read of 0x00 is in flight.
        b0.addr = 8'h00; b0.MemRead = 1;
        @(posedge Clk); #1;
        b0.addr = 8'h01;
        @(posedge Clk); #1;
        checks++; if (b0.MemReady !== 1'b1) begin failures++; $display("FAIL w0_addr_change_ready got=%0h exp=1", b0.MemReady); end
        checks++; if (b0.rdata !== 16'hABCD) begin failures++; $display("FAIL w0_addr_latched got=%0h exp=abcd", b0.rdata); end
        b0.MemRead = 0;
        @(posedge Clk); #1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_both_strobes();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_wait0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
